// File: rtl/uplink_scheduler_if.sv
// Uplink scheduler bus bundle: ACK request/generator handshake, source
// request/grant/data lanes and the serializer-facing byte stream.
interface uplink_scheduler_if #(
  parameter int unsigned NUM_SRC = 2
);
  logic                   ack_req;
  logic                   nak_req;
  logic [7:0]             req_eid;
  logic                   ackq_full;
  logic                   ackq_overflow;
  logic                   gen_ack;
  logic                   gen_nak;
  logic [7:0]             gen_eid;
  logic [7:0]             ag_data;
  logic                   ag_data_valid;
  logic                   ag_frame_valid;
  logic [NUM_SRC-1:0]     src_req;
  logic [NUM_SRC-1:0]     src_grant;
  logic [8*NUM_SRC-1:0]   src_data;
  logic [NUM_SRC-1:0]     src_data_valid;
  logic [NUM_SRC-1:0]     src_frame_valid;
  logic [7:0]             out_data;
  logic                   out_data_valid;
  logic                   out_frame_valid;

  // Scheduler side.
  modport master (
    input  ack_req, nak_req, req_eid, ag_data, ag_data_valid, ag_frame_valid,
           src_req, src_data, src_data_valid, src_frame_valid,
    output ackq_full, ackq_overflow, gen_ack, gen_nak, gen_eid, src_grant,
           out_data, out_data_valid, out_frame_valid
  );

  // Decoder / ACK generator / sources / serializer side.
  modport slave (
    output ack_req, nak_req, req_eid, ag_data, ag_data_valid, ag_frame_valid,
           src_req, src_data, src_data_valid, src_frame_valid,
    input  ackq_full, ackq_overflow, gen_ack, gen_nak, gen_eid, src_grant,
           out_data, out_data_valid, out_frame_valid
  );
endinterface

// File: rtl/uplink_scheduler.sv
// Uplink byte-stream scheduler: queued ACK/NAK frames take priority, general
// sources are served round-robin. The output is a combinational mux steered by
// the registered state and current source index.
module uplink_scheduler #(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned ACKQ_AW       = 2,
  parameter int unsigned START_TIMEOUT = 16
) (
  input logic                clk,
  input logic                reset,
  uplink_scheduler_if.master bus
);

  localparam int unsigned Depth  = 1 << ACKQ_AW;
  localparam int unsigned IdxW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned TimerW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StAckStart, StAckBusy, StSrcBusy, StGap} state_e;

  state_e            state_q, state_d;
  logic [8:0]        ackq_mem [Depth];
  logic [ACKQ_AW:0]  wr_ptr_q, rd_ptr_q;
  logic              ackq_empty, ackq_full_int;
  logic              push, push_ok, pop;
  logic [8:0]        head;
  logic [IdxW-1:0]   cur_q, cur_d, last_q, last_d, rr_idx;
  logic              rr_found;
  int unsigned       cand;
  logic              seen_q, seen_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              busy_fv;

  assign push          = bus.ack_req | bus.nak_req;
  assign ackq_empty    = (wr_ptr_q == rd_ptr_q);
  assign ackq_full_int = (wr_ptr_q[ACKQ_AW] != rd_ptr_q[ACKQ_AW]) &&
                         (wr_ptr_q[ACKQ_AW-1:0] == rd_ptr_q[ACKQ_AW-1:0]);
  // A push into a full queue still lands if the head leaves in the same cycle.
  assign push_ok       = push & (~ackq_full_int | pop);
  assign head          = ackq_mem[rd_ptr_q[ACKQ_AW-1:0]];

  assign bus.ackq_full     = ackq_full_int;
  assign bus.ackq_overflow = push & ackq_full_int & ~pop;
  assign bus.gen_ack       = (state_q == StAckStart) & ~head[8];
  assign bus.gen_nak       = (state_q == StAckStart) &  head[8];
  assign bus.gen_eid       = ackq_empty ? 8'h00 : head[7:0];

  // Frame-valid of whichever side currently owns the uplink.
  assign busy_fv = (state_q == StAckBusy) ? bus.ag_frame_valid : bus.src_frame_valid[cur_q];

  // ACK queue pointers; extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ACK queue storage; NAK wins when both request pulses coincide.
  always_ff @(posedge clk) begin
    if (push_ok) ackq_mem[wr_ptr_q[ACKQ_AW-1:0]] <= {bus.nak_req, bus.req_eid};
  end

  // Round-robin search starting just after the last-served source.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(last_q) + k) % NUM_SRC;
      if (!rr_found && bus.src_req[IdxW'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(cand);
      end
    end
  end

  // Scheduler state and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      last_q  <= IdxW'(NUM_SRC - 1);
      seen_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      seen_q  <= seen_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: ACKs first, then sources; a frame ends on the fall of
  // frame_valid once it has been seen, or on start timeout.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    seen_d  = seen_q;
    timer_d = timer_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ackq_empty || push_ok) begin
          state_d = StAckStart;
        end else if (rr_found) begin
          state_d = StSrcBusy;
          cur_d   = rr_idx;
          seen_d  = 1'b0;
          timer_d = '0;
        end
      end
      StAckStart: begin
        state_d = StAckBusy;
        seen_d  = 1'b0;
        timer_d = '0;
      end
      StAckBusy, StSrcBusy: begin
        if (busy_fv) seen_d = 1'b1;
        if (!busy_fv && (seen_q || timer_q == TimerW'(START_TIMEOUT - 1))) begin
          state_d = StGap;
          if (state_q == StAckBusy) pop = 1'b1;
          else                      last_d = cur_q;
        end else if (!busy_fv && !seen_q) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output mux and grant; silent outside the two BUSY states.
  always_comb begin
    bus.out_data        = 8'h00;
    bus.out_data_valid  = 1'b0;
    bus.out_frame_valid = 1'b0;
    bus.src_grant       = '0;
    if (state_q == StAckBusy) begin
      bus.out_data        = bus.ag_data;
      bus.out_data_valid  = bus.ag_data_valid;
      bus.out_frame_valid = bus.ag_frame_valid;
    end else if (state_q == StSrcBusy) begin
      bus.src_grant       = NUM_SRC'(1) << cur_q;
      bus.out_data        = bus.src_data[cur_q*8 +: 8];
      bus.out_data_valid  = bus.src_data_valid[cur_q];
      bus.out_frame_valid = bus.src_frame_valid[cur_q];
    end
  end

endmodule
